seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed, active-low 4-digit 7-segment display bus and
// recovers the BCD value being shown. Each anode dwell is debounced, the
// segment pattern is decoded into a nibble, and a complete four-digit frame is
// published once all four digit positions have been captured.
//
// Parameters
//   STABLE_CYCLES  consecutive identical synchronized samples needed before a
//                  digit is captured (minimum 1)
//   TIMEOUT        cycles without any capture before stall_o is raised
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   seg_i[6:0]     segment bus, active-low, bit0 = a ... bit6 = g
//   an_i[3:0]      digit enables, active-low, an_i[0] = rightmost digit
//   digits_o[15:0] last complete frame, digit n at [4n+3:4n]
//   frame_valid_o  one-cycle pulse when digits_o updates
//   err_o          last frame contained an unrecognised pattern
//   stall_o        no capture seen for TIMEOUT cycles
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  an_i,
  output logic [15:0] digits_o,
  output logic        frame_valid_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX      = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT - 1);

  // Bus sample layout: {an[3:0], seg[6:0]}; all ones is "nothing lit".
  logic [10:0] sync1, sync2, prev;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;

  logic [CW-1:0] stable_cnt, stable_cnt_next;
  logic          an_valid;
  logic [1:0]    slot_idx;
  logic          capture;

  logic [3:0]  dec_val;
  logic        dec_inv;

  logic [15:0] slots, slots_next;
  logic [3:0]  inv, inv_next;
  logic [3:0]  seen, seen_next;
  logic        frame_done;

  logic [WW-1:0] wd_cnt;
  logic          wd_hit;

  assign an_s  = sync2[10:7];
  assign seg_s = sync2[6:0];

  // Two-flop synchronizer plus a one-cycle history register used to detect
  // when the synchronized bus changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {an_i, seg_i};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Only a single active-low anode selects a slot; idle and multi-digit
  // enables are treated as unusable samples.
  always_comb begin
    an_valid = 1'b1;
    slot_idx = 2'd0;
    case (an_s)
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  // Stability counter: restarts on any change or unusable anode, otherwise
  // climbs and parks at STABLE_CYCLES so a long dwell captures only once.
  always_comb begin
    stable_cnt_next = stable_cnt;
    if (!an_valid || (sync2 != prev)) begin
      stable_cnt_next = '0;
    end else if (stable_cnt != STABLE_MAX) begin
      stable_cnt_next = stable_cnt + 1'b1;
    end
  end

  assign capture = an_valid && (sync2 == prev) && (stable_cnt == STABLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt_next;
    end
  end

  // Active-low segment pattern to digit. 4'hE is a legal glyph; anything
  // unrecognised becomes 4'hF and is flagged.
  always_comb begin
    dec_inv = 1'b0;
    case (seg_s)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0011000: dec_val = 4'h9;
      7'b0000110: dec_val = 4'hE;
      default: begin
        dec_val = 4'hF;
        dec_inv = 1'b1;
      end
    endcase
  end

  assign frame_done = (seen == 4'hF);
  assign wd_hit     = !capture && (wd_cnt == WD_LAST);

  // Frame assembly. The clear from a frame transfer or a watchdog timeout is
  // applied first so that a capture in the same cycle starts the new frame.
  always_comb begin
    slots_next = slots;
    inv_next   = inv;
    seen_next  = seen;
    if (frame_done || wd_hit) begin
      inv_next  = '0;
      seen_next = '0;
    end
    if (capture) begin
      slots_next[{slot_idx, 2'b00} +: 4] = dec_val;
      inv_next[slot_idx]                 = dec_inv;
      seen_next[slot_idx]                = 1'b1;
    end
  end

  // Slot storage and the published frame. digits_o/err_o move only together
  // with the frame_valid_o pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots         <= '0;
      inv           <= '0;
      seen          <= '0;
      digits_o      <= '0;
      err_o         <= 1'b0;
      frame_valid_o <= 1'b0;
    end else begin
      slots         <= slots_next;
      inv           <= inv_next;
      seen          <= seen_next;
      frame_valid_o <= frame_done;
      if (frame_done) begin
        digits_o <= slots;
        err_o    <= |inv;
      end
    end
  end

  // Watchdog: counts cycles since the last capture and parks at TIMEOUT,
  // holding stall_o until capturing resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      stall_o <= 1'b0;
    end else if (capture) begin
      wd_cnt  <= '0;
      stall_o <= 1'b0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) begin
        stall_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Drives scanned 7-segment patterns into seg7_scan_decoder. Each full scan
// pushes its expected {err, digits} onto a queue; a monitor pops an entry on
// every frame_valid_o pulse and compares. Stall and reset behaviour are
// checked directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_i;
  logic [3:0]  an_i;
  logic [15:0] digits_o;
  logic        frame_valid_o;
  logic        err_o;
  logic        stall_o;

  int checkCount = 0;
  int passCount  = 0;

  logic [16:0] expQ[$];
  logic [16:0] expItem;
  logic        prevFv = 1'b0;
  logic [15:0] prevDigits = '0;

  seg7_scan_decoder #(
    .STABLE_CYCLES(STABLE),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_i(seg_i),
    .an_i(an_i),
    .digits_o(digits_o),
    .frame_valid_o(frame_valid_o),
    .err_o(err_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference glyph table, active-low gfedcba.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'h0: segOf = 7'b1000000;
      4'h1: segOf = 7'b1111001;
      4'h2: segOf = 7'b0100100;
      4'h3: segOf = 7'b0110000;
      4'h4: segOf = 7'b0011001;
      4'h5: segOf = 7'b0010010;
      4'h6: segOf = 7'b0000010;
      4'h7: segOf = 7'b1111000;
      4'h8: segOf = 7'b0000000;
      4'h9: segOf = 7'b0011000;
      4'hE: segOf = 7'b0000110;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // Hold one bus value for a number of cycles; called on a falling edge.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg,
                               input int cycles);
    an_i  = an;
    seg_i = seg;
    repeat (cycles) @(negedge clk);
  endtask

  // One full right-to-left scan with an 8-cycle dwell per digit, followed by
  // a short idle gap.
  task automatic scanFrame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [15:0] expDigits, input logic expErr);
    expQ.push_back({expErr, expDigits});
    applyStimulus(4'b1110, s0, 8);
    applyStimulus(4'b1101, s1, 8);
    applyStimulus(4'b1011, s2, 8);
    applyStimulus(4'b0111, s3, 8);
    applyStimulus(4'b1111, 7'h7F, 4);
  endtask

  // Frame monitor: scoreboard pop on each pulse, plus checks that the pulse
  // lasts one cycle and that digits_o never moves between pulses.
  always @(negedge clk) begin
    if (frame_valid_o) begin
      checkOutput("fv_one_cycle", 32'(prevFv), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("frame_digits", 32'(digits_o), 32'(expItem[15:0]));
        checkOutput("frame_err", 32'(err_o), 32'(expItem[16]));
      end
    end else if (rst_n && (digits_o !== prevDigits)) begin
      checkOutput("digits_hold", 32'(digits_o), 32'(prevDigits));
    end
    prevFv     = frame_valid_o;
    prevDigits = digits_o;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst_n = 1'b0;
    an_i  = 4'hF;
    seg_i = 7'h7F;
    repeat (3) @(negedge clk);
    checkOutput("reset_digits", 32'(digits_o), 32'd0);
    checkOutput("reset_fv", 32'(frame_valid_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean scan 1,2,3,4");
    scanFrame(segOf(4'h1), segOf(4'h2), segOf(4'h3), segOf(4'h4), 16'h4321, 1'b0);
    checkOutput("stall_while_scanning", 32'(stall_o), 32'd0);

    $display("[TB] unrecognised pattern on digit 2, then clean frame");
    scanFrame(segOf(4'h1), segOf(4'h2), 7'b1010101, segOf(4'h4), 16'h4F21, 1'b1);
    scanFrame(segOf(4'h5), segOf(4'h6), segOf(4'h7), segOf(4'h8), 16'h8765, 1'b0);

    $display("[TB] short glitch and two-anode dwell");
    expQ.push_back({1'b0, 16'h2109});
    applyStimulus(4'b1110, segOf(4'h9), 6);
    applyStimulus(4'b1110, 7'b1010101, 2);
    applyStimulus(4'b1110, segOf(4'h9), 2);
    applyStimulus(4'b1100, segOf(4'h3), 12);
    applyStimulus(4'b1101, segOf(4'h0), 8);
    applyStimulus(4'b1011, segOf(4'h1), 8);
    applyStimulus(4'b0111, segOf(4'h2), 8);
    applyStimulus(4'b1111, 7'h7F, 4);

    $display("[TB] E glyph on all digits");
    scanFrame(segOf(4'hE), segOf(4'hE), segOf(4'hE), segOf(4'hE), 16'hEEEE, 1'b0);

    $display("[TB] watchdog timeout with partial frame");
    applyStimulus(4'b1110, segOf(4'h5), 8);
    applyStimulus(4'b1101, segOf(4'h6), 8);
    applyStimulus(4'b1110, segOf(4'h5), 40);
    checkOutput("stall_before_timeout", 32'(stall_o), 32'd0);
    applyStimulus(4'b1110, segOf(4'h5), 60);
    checkOutput("stall_at_timeout", 32'(stall_o), 32'd1);
    checkOutput("digits_kept_on_stall", 32'(digits_o), 32'h0000EEEE);
    expQ.push_back({1'b0, 16'h8709});
    applyStimulus(4'b1011, segOf(4'h7), 8);
    checkOutput("stall_cleared", 32'(stall_o), 32'd0);
    applyStimulus(4'b0111, segOf(4'h8), 8);
    applyStimulus(4'b1110, segOf(4'h9), 8);
    applyStimulus(4'b1101, segOf(4'h0), 8);
    applyStimulus(4'b1111, 7'h7F, 4);

    $display("[TB] reset after three captures");
    applyStimulus(4'b1110, segOf(4'h1), 8);
    applyStimulus(4'b1101, segOf(4'h2), 8);
    applyStimulus(4'b1011, segOf(4'h3), 8);
    #1 rst_n = 1'b0;
    an_i  = 4'hF;
    seg_i = 7'h7F;
    #1;
    checkOutput("midreset_digits", 32'(digits_o), 32'd0);
    checkOutput("midreset_fv", 32'(frame_valid_o), 32'd0);
    checkOutput("midreset_err", 32'(err_o), 32'd0);
    checkOutput("midreset_stall", 32'(stall_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back({1'b0, 16'h4765});
    applyStimulus(4'b0111, segOf(4'h4), 8);
    applyStimulus(4'b1110, segOf(4'h5), 8);
    applyStimulus(4'b1101, segOf(4'h6), 8);
    applyStimulus(4'b1011, segOf(4'h7), 8);
    applyStimulus(4'b1111, 7'h7F, 4);

    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("frames_pending", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
